// File: rtl/break_clause_fifo.sv
// Collects zero-true-literal (broken) clauses seen during a flip scan window into a FWFT FIFO.
// Candidate -> FIFO visible after 2 edges; pushes into a full FIFO are dropped and flagged sticky overflow.
module break_clause_fifo #(
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH            = 16,
  localparam int CW = NSAT * LITERAL_ADDRESS_WIDTH,
  localparam int TW = $clog2(NSAT + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          scan_start_i,
  input  logic          scan_end_i,
  input  logic          cand_valid_i,
  input  logic [CW-1:0] cand_clause_i,
  input  logic [TW-1:0] cand_true_cnt_i,
  input  logic          pop_i,
  input  logic          clear_overflow_i,
  output logic          fifo_empty_o,
  output logic [CW-1:0] fifo_clause_o,
  output logic          fifo_last_o,
  output logic [AW:0]   fifo_count_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic          filt_vld_q, filt_vld_d;
  logic [CW-1:0] filt_clause_q, filt_clause_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] mem_q [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic pop_eff;
  logic push_eff;
  logic push_drop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_start_i) state_d = COLLECT;
      COLLECT: if (scan_end_i)   state_d = FLUSH;
      FLUSH:                     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Only clauses left with no true literal are broken and worth queuing.
  always_comb begin
    filt_vld_d    = (state_q == COLLECT) && cand_valid_i && (cand_true_cnt_i == '0);
    filt_clause_d = filt_vld_d ? cand_clause_i : filt_clause_q;
  end

  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    pop_eff    = pop_i && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push_eff   = filt_vld_q && (!fifo_full || pop_eff);
    push_drop  = filt_vld_q && fifo_full && !pop_eff;

    wr_ptr_d = push_eff ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_eff  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      filt_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      filt_vld_q <= filt_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    filt_clause_q <= filt_clause_d;
    if (push_eff) begin
      mem_q[wr_ptr_q] <= filt_clause_q;
    end
  end

  always_comb begin
    fifo_empty_o  = fifo_empty;
    fifo_last_o   = (count_q == (AW+1)'(1));
    fifo_count_o  = count_q;
    fifo_clause_o = fifo_empty ? '0 : mem_q[rd_ptr_q];
    overflow_o    = overflow_q;
    busy_o        = (state_q != IDLE) || filt_vld_q;
    done_o        = (state_q == FLUSH);
  end

endmodule

// File: doc/break_clause_fifo.md
BREAK_CLAUSE_FIFO -- requirements
Module: break_clause_fifo

Interface
REQ-001 Parameters SHALL be NSAT (default 3, literals per clause), LITERAL_ADDRESS_WIDTH (default 12, bits per literal address) and FIFO_DEPTH (default 16, entries, power of 2); CW = NSAT*LITERAL_ADDRESS_WIDTH, TW = clog2(NSAT+1), AW = clog2(FIFO_DEPTH).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_ni  input  1  synchronous active-low reset.
REQ-005 scan_start_i  input  1  one-cycle pulse that opens a collection window after a variable flip.
REQ-006 scan_end_i  input  1  one-cycle pulse that marks the last candidate of the window; it may coincide with that candidate.
REQ-007 cand_valid_i  input  1  candidate clause valid.
REQ-008 cand_clause_i  input  CW  candidate clause literals.
REQ-009 cand_true_cnt_i  input  TW  number of true literals in the candidate after the flip.
REQ-010 pop_i  input  1  consumer takes the head entry.
REQ-011 clear_overflow_i  input  1  clears the sticky overflow flag.
REQ-012 fifo_empty_o  output  1  no entries are stored.
REQ-013 fifo_clause_o  output  CW  head entry, first-word-fall-through.
REQ-014 fifo_last_o  output  1  exactly one entry is stored.
REQ-015 fifo_count_o  output  AW+1  occupancy.
REQ-016 overflow_o  output  1  sticky flag: a push was dropped.
REQ-017 busy_o  output  1  a collection window is open or the filter stage still holds data.
REQ-018 done_o  output  1  one-cycle pulse: the window is closed and all of its writes are committed.

Function
REQ-019 The FSM SHALL have three states: IDLE, COLLECT and FLUSH.
REQ-020 IDLE SHALL go to COLLECT on scan_start_i.
REQ-021 COLLECT SHALL go to FLUSH on scan_end_i.
REQ-022 FLUSH SHALL last exactly one cycle, then return to IDLE; done_o SHALL be high during that FLUSH cycle.
REQ-023 scan_start_i outside IDLE SHALL be ignored.
REQ-024 scan_end_i outside COLLECT SHALL be ignored.
REQ-025 Candidates SHALL be accepted only in COLLECT, including the scan_end_i cycle; cand_valid_i in any other state SHALL be dropped without setting overflow.
REQ-026 Filter stage: an accepted candidate with cand_true_cnt_i == 0 SHALL be registered at edge N+1 and written to the FIFO at edge N+2; any other count SHALL be discarded.
REQ-027 Latency SHALL be: candidate at cycle N -> fifo_empty_o low from cycle N+2, when the FIFO was previously empty.
REQ-028 Order: FIFO order SHALL equal the candidate arrival order.
REQ-029 busy_o SHALL be high in COLLECT and FLUSH, and whenever the filter stage is valid.
REQ-030 When the FIFO is not empty, fifo_clause_o SHALL show the oldest entry combinationally from storage; when empty it SHALL be all zeros.
REQ-031 Pop SHALL be effective only when pop_i = 1 and the FIFO is not empty; a pop on empty SHALL be ignored, with no bypass from a same-cycle push.
REQ-032 Push when the FIFO is not full SHALL be accepted.
REQ-033 Push when full without an effective pop SHALL be dropped and SHALL set overflow_o at the next edge.
REQ-034 Push and pop when full SHALL both be accepted, leaving the count at FIFO_DEPTH.
REQ-035 An effective push and an effective pop in the same cycle SHALL leave the count unchanged and advance both pointers.
REQ-036 Read and write pointers SHALL be AW bits wide and SHALL wrap modulo FIFO_DEPTH with no gap.
REQ-037 fifo_count_o SHALL be a registered counter in the range 0..FIFO_DEPTH.
REQ-038 fifo_empty_o SHALL equal (count == 0) and fifo_last_o SHALL equal (count == 1).
REQ-039 overflow_o SHALL be cleared by clear_overflow_i at the next edge; a simultaneous dropped push SHALL win, leaving overflow_o at 1.
REQ-040 The FIFO contents SHALL persist across windows; only reset empties the FIFO.

Reset
REQ-041 While rst_ni = 0 at an edge, the following SHALL be forced: state = IDLE, filter stage invalid, both pointers = 0, count = 0, overflow_o = 0.
REQ-042 Reset values SHALL then read fifo_empty_o = 1, fifo_last_o = 0, fifo_count_o = 0, busy_o = 0, done_o = 0 and fifo_clause_o = 0.
REQ-043 Reset mid-window SHALL discard any in-flight candidate, and done_o SHALL not pulse for that window.
REQ-044 The storage array itself SHALL not require reset.

Verification
REQ-045 Basic window: scan_start_i at cycle 0; candidates A(cnt 0), B(cnt 1), C(cnt 0) at cycles 1-3, with scan_end_i at cycle 3 -> FIFO holds A,C; fifo_count_o = 1 at cycle 3 and 2 at cycle 5; done_o high at cycle 4; busy_o low from cycle 5.
REQ-046 Fill and overflow (FIFO_DEPTH = 16): 17 zero-count candidates with no pops -> count = 16; overflow_o = 1 after the 17th write edge; the head is still the 1st entry.
REQ-047 Full push+pop: with the FIFO full, a push and a pop in the same cycle -> count stays 16; the head becomes the 2nd entry; overflow_o is unchanged.
REQ-048 Wrap-around: 40 pushes interleaved with pops, occupancy kept at 1..3 -> pop order equals push order across 2+ pointer wraps; fifo_last_o is high exactly when count = 1.
REQ-049 Edge cases:
- pop on empty together with a push -> the pop is ignored and count = 1 next cycle;
- cand_valid_i in IDLE -> no write and no overflow.
REQ-050 Reset mid-operation: rst_ni low at cycle 2 of a window with candidates in flight -> all outputs at reset values next cycle; no done_o pulse.
